// File: rtl/hamming_min_tracker.sv
// Tracks the minimum clamped Hamming distance over a frame of candidates and
// presents one held result beat (min, first index, tie, match, error) per frame.
module hamming_min_tracker #(
  parameter int unsigned DIST_W    = 5,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned MAX_DIST  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIST_W-1:0] in_dist,
  input  logic [DIST_W-1:0] thresh,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIST_W-1:0] out_min_dist,
  output logic [IDX_W-1:0]  out_min_idx,
  output logic              out_tie,
  output logic              out_match,
  output logic              out_err
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIST_W-1:0]   min_q, min_d;
  logic                tie_q, tie_d;
  logic                err_q, err_d;
  logic [DIST_W-1:0]   d_clamped;
  logic                clamp;
  logic                accept;
  logic                last;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);

  // Running-minimum update for the current entry, including the frame's last one.
  always_comb begin
    clamp     = (in_dist > DIST_W'(MAX_DIST));
    d_clamped = clamp ? DIST_W'(MAX_DIST) : in_dist;
    accept    = in_valid & in_ready;
    last      = (count_q == IDX_W'(FRAME_LEN - 1));
    count_d   = count_q;
    idx_d     = idx_q;
    min_d     = min_q;
    tie_d     = tie_q;
    err_d     = err_q;
    if (accept) begin
      count_d = last ? '0 : count_q + IDX_W'(1);
      if (count_q == '0) begin
        min_d = d_clamped;
        idx_d = '0;
        tie_d = 1'b0;
        err_d = clamp;
      end else begin
        if (d_clamped < min_q) begin
          min_d = d_clamped;
          idx_d = count_q;
          tie_d = 1'b0;
        end else if (d_clamped == min_q) begin
          tie_d = 1'b1;
        end
        err_d = err_q | clamp;
      end
    end
  end

  // State, running accumulators and the held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      count_q      <= '0;
      min_q        <= DIST_W'(MAX_DIST);
      idx_q        <= '0;
      tie_q        <= 1'b0;
      err_q        <= 1'b0;
      out_min_dist <= '0;
      out_min_idx  <= '0;
      out_tie      <= 1'b0;
      out_match    <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      count_q <= count_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
      tie_q   <= tie_d;
      err_q   <= err_d;
      case (state_q)
        ACCUM: begin
          if (accept && last) begin
            state_q      <= DONE;
            out_min_dist <= min_d;
            out_min_idx  <= idx_d;
            out_tie      <= tie_d;
            out_err      <= err_d;
            out_match    <= (min_d <= thresh);
          end
        end
        DONE: begin
          if (out_ready) state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_min_tracker.sv
// Directed and randomised frame checks for hamming_min_tracker.
module tb_hamming_min_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_dist;
  logic [4:0] thresh;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_min_dist;
  logic [3:0] out_min_idx;
  logic       out_tie;
  logic       out_match;
  logic       out_err;

  hamming_min_tracker #(
    .DIST_W(5), .IDX_W(4), .FRAME_LEN(16), .MAX_DIST(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist), .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min_dist(out_min_dist), .out_min_idx(out_min_idx),
    .out_tie(out_tie), .out_match(out_match), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0][4:0] d;
    logic [4:0]       th;
    logic [4:0]       emin;
    logic [3:0]       eidx;
    logic             etie;
    logic             ematch;
    logic             eerr;
  } vec_t;

  localparam int NVEC = 5;
  vec_t             vecs [NVEC];
  logic [15:0][4:0] cur_d;
  logic             hold_ready;
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one entry and hold it until accepted.
  task automatic send(input logic [4:0] d, input logic [4:0] th);
    int budget;
    budget   = 50;
    in_valid = 1'b1;
    in_dist  = d;
    thresh   = th;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) chk("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_dist  = 5'd31;
  endtask

  task automatic run_frame(input bit gaps, input logic [4:0] th);
    for (int i = 0; i < 16; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) tick();
      if (i == 15) chk("pre_last_out_valid", int'(out_valid), 0);
      send(cur_d[i], th);
    end
    chk("latency_out_valid", int'(out_valid), 1);
    chk("done_in_ready", int'(in_ready), 0);
  endtask

  task automatic check_out(input logic [4:0] emin, input logic [3:0] eidx,
                           input logic etie, input logic ematch, input logic eerr);
    chk("min_dist", int'(out_min_dist), int'(emin));
    chk("min_idx", int'(out_min_idx), int'(eidx));
    chk("tie", int'(out_tie), int'(etie));
    chk("match", int'(out_match), int'(ematch));
    chk("err", int'(out_err), int'(eerr));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = hold_ready;
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    logic [4:0] mn, dc, th;
    logic [3:0] ei;
    int         occ;
    logic       er;

    // Table of directed frames and their hand-computed results.
    for (int v = 0; v < NVEC; v++) vecs[v] = '0;
    for (int i = 0; i < 16; i++) begin
      vecs[0].d[i] = 5'd8;
      vecs[1].d[i] = 5'd7;
      vecs[2].d[i] = 5'd16;
      vecs[3].d[i] = 5'd10;
      vecs[4].d[i] = 5'd9;
    end
    vecs[0].d[5] = 5'd3;
    vecs[0].th = 5'd4;  vecs[0].emin = 5'd3;  vecs[0].eidx = 4'd5;
    vecs[0].etie = 1'b0; vecs[0].ematch = 1'b1; vecs[0].eerr = 1'b0;
    vecs[1].d[2] = 5'd1; vecs[1].d[9] = 5'd1;
    vecs[1].th = 5'd0;  vecs[1].emin = 5'd1;  vecs[1].eidx = 4'd2;
    vecs[1].etie = 1'b1; vecs[1].ematch = 1'b0; vecs[1].eerr = 1'b0;
    vecs[2].d[3] = 5'd20;
    vecs[2].th = 5'd16; vecs[2].emin = 5'd16; vecs[2].eidx = 4'd0;
    vecs[2].etie = 1'b1; vecs[2].ematch = 1'b1; vecs[2].eerr = 1'b1;
    vecs[3].d[0] = 5'd31; vecs[3].d[15] = 5'd2;
    vecs[3].th = 5'd2;  vecs[3].emin = 5'd2;  vecs[3].eidx = 4'd15;
    vecs[3].etie = 1'b0; vecs[3].ematch = 1'b1; vecs[3].eerr = 1'b1;
    vecs[4].d[1] = 5'd4; vecs[4].d[2] = 5'd4; vecs[4].d[10] = 5'd2;
    vecs[4].th = 5'd1;  vecs[4].emin = 5'd2;  vecs[4].eidx = 4'd10;
    vecs[4].etie = 1'b0; vecs[4].ematch = 1'b0; vecs[4].eerr = 1'b0;

    rst = 1'b1; in_valid = 1'b0; in_dist = 5'd0; thresh = 5'd0;
    out_ready = 1'b0; hold_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    check_out(5'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    for (int v = 0; v < NVEC; v++) begin
      cur_d = vecs[v].d;
      run_frame(1'b0, vecs[v].th);
      check_out(vecs[v].emin, vecs[v].eidx, vecs[v].etie, vecs[v].ematch, vecs[v].eerr);
      release_out();
      check_out(vecs[v].emin, vecs[v].eidx, vecs[v].etie, vecs[v].ematch, vecs[v].eerr);
    end

    // Backpressure: result held and input refused while out_ready stays low.
    cur_d = vecs[0].d;
    run_frame(1'b0, vecs[0].th);
    in_valid = 1'b1; in_dist = 5'd0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_min", int'(out_min_dist), 3);
      chk("hold_idx", int'(out_min_idx), 5);
    end
    in_valid = 1'b0;
    release_out();

    // Reset mid-frame discards the partial frame and clears the result.
    for (int i = 0; i < 7; i++) send(5'd1, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_min", int'(out_min_dist), 0);
    chk("midrst_idx", int'(out_min_idx), 0);
    for (int i = 0; i < 16; i++) cur_d[i] = 5'(i);
    run_frame(1'b0, 5'd0);
    check_out(5'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    release_out();

    // Random gapped frames with out_ready held high, against a reference model.
    hold_ready = 1'b1;
    out_ready  = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) cur_d[i] = 5'($urandom_range(0, 20));
      th = 5'($urandom_range(0, 16));
      mn = 5'd16; er = 1'b0;
      for (int i = 0; i < 16; i++) begin
        dc = (cur_d[i] > 5'd16) ? 5'd16 : cur_d[i];
        if (cur_d[i] > 5'd16) er = 1'b1;
        if (dc < mn) mn = dc;
      end
      occ = 0; ei = 4'd0;
      for (int i = 15; i >= 0; i--) begin
        dc = (cur_d[i] > 5'd16) ? 5'd16 : cur_d[i];
        if (dc == mn) begin
          occ++;
          ei = 4'(i);
        end
      end
      run_frame(1'b1, th);
      check_out(mn, ei, occ >= 2, mn <= th, er);
      release_out();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
